// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller between a byte UART and a combinational ALU: collects two
// little-endian operands plus an opcode, then streams the latched result back.
module uart_alu_frame_ctrl #(
    parameter int DATA_W        = 16,
    parameter int TIMEOUT_TICKS = 16'd4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        from_rx,
    input  logic              tx_done,
    input  logic              tick,
    input  logic [DATA_W-1:0] from_alu,
    output logic [DATA_W-1:0] num_a,
    output logic [DATA_W-1:0] num_b,
    output logic [7:0]        opcode,
    output logic [7:0]        to_tx,
    output logic              tx_start,
    output logic [7:0]        leds,
    output logic              busy,
    output logic              frame_err,
    output logic [2:0]        fsm_state
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    localparam logic [2:0] NUMA   = 3'd0;
    localparam logic [2:0] NUMB   = 3'd1;
    localparam logic [2:0] OPCODE = 3'd2;
    localparam logic [2:0] LATCH  = 3'd3;
    localparam logic [2:0] SEND   = 3'd4;
    localparam logic [2:0] WAIT   = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_TICKS);

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] result;
    logic [7:0]        result_byte;
    logic              rx_phase;
    logic              idle;
    logic              timeout_hit;

    assign rx_phase    = (state == NUMA) || (state == NUMB) || (state == OPCODE);
    assign idle        = (state == NUMA) && (idx == '0);
    assign timeout_hit = (TIMEOUT_TICKS != 0) && rx_phase && !idle && (cnt == CNT_LIMIT);
    assign busy        = (state == LATCH) || (state == SEND) || (state == WAIT);
    assign fsm_state   = state;

    always_comb begin
        result_byte = result[7:0];
        for (int i = 1; i < NB; i++) begin
            if (idx == IDX_W'(i)) result_byte = result[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= NUMA;
            idx       <= '0;
            cnt       <= '0;
            result    <= '0;
            num_a     <= '0;
            num_b     <= '0;
            opcode    <= '0;
            to_tx     <= '0;
            leds      <= '0;
            tx_start  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            frame_err <= 1'b0;

            if (rx_done || idle) begin
                cnt <= '0;
            end else if (rx_phase && tick && (TIMEOUT_TICKS != 0)) begin
                cnt <= cnt + 1'b1;
            end

            // A byte arriving in the same cycle as the timeout keeps the frame alive.
            if (timeout_hit && !rx_done) begin
                state     <= NUMA;
                idx       <= '0;
                cnt       <= '0;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    NUMA: begin
                        if (rx_done) begin
                            for (int i = 0; i < NB; i++) begin
                                if (idx == IDX_W'(i)) num_a[8*i +: 8] <= from_rx;
                            end
                            leds <= from_rx;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= NUMB;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    NUMB: begin
                        if (rx_done) begin
                            for (int i = 0; i < NB; i++) begin
                                if (idx == IDX_W'(i)) num_b[8*i +: 8] <= from_rx;
                            end
                            leds <= from_rx;
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= OPCODE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    OPCODE: begin
                        if (rx_done) begin
                            opcode <= from_rx;
                            leds   <= from_rx;
                            state  <= LATCH;
                        end
                    end
                    LATCH: begin
                        result <= from_alu;
                        idx    <= '0;
                        state  <= SEND;
                    end
                    SEND: begin
                        to_tx    <= result_byte;
                        leds     <= result_byte;
                        tx_start <= 1'b1;
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (tx_done) begin
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= NUMA;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= SEND;
                            end
                        end
                    end
                    default: begin
                        state <= NUMA;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Randomized bench for uart_alu_frame_ctrl: a default-timeout instance and a
// timeout-disabled instance share stimulus; expected bytes come from a frame-level model.
module tb_uart_alu_frame_ctrl;

    localparam int DATA_W = 16;
    localparam int NB     = DATA_W / 8;
    localparam int T      = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_done;
    logic [7:0]        from_rx;
    logic              tx_done;
    logic              tick;
    logic [DATA_W-1:0] from_alu, num_a, num_b;
    logic [7:0]        opcode, to_tx, leds;
    logic              tx_start, busy, frame_err;
    logic [2:0]        fsm_state;
    logic [DATA_W-1:0] z_from_alu, z_num_a, z_num_b;
    logic [7:0]        z_opcode, z_to_tx, z_leds;
    logic              z_tx_start, z_busy, z_frame_err;
    logic [2:0]        z_fsm_state;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    int fe0_count = 0;
    int txs_count = 0;
    logic prev_tx = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a, b, input logic [7:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign from_alu   = alu_fn(num_a, num_b, opcode);
    assign z_from_alu = alu_fn(z_num_a, z_num_b, z_opcode);

    uart_alu_frame_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .from_rx(from_rx),
        .tx_done(tx_done), .tick(tick), .from_alu(from_alu),
        .num_a(num_a), .num_b(num_b), .opcode(opcode), .to_tx(to_tx),
        .tx_start(tx_start), .leds(leds), .busy(busy), .frame_err(frame_err),
        .fsm_state(fsm_state)
    );

    uart_alu_frame_ctrl #(.DATA_W(DATA_W), .TIMEOUT_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .rx_done(rx_done), .from_rx(from_rx),
        .tx_done(tx_done), .tick(tick), .from_alu(z_from_alu),
        .num_a(z_num_a), .num_b(z_num_b), .opcode(z_opcode), .to_tx(z_to_tx),
        .tx_start(z_tx_start), .leds(z_leds), .busy(z_busy), .frame_err(z_frame_err),
        .fsm_state(z_fsm_state)
    );

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && tx_start === 1'b1) begin
            checks++;
            if (prev_tx === 1'b1) begin
                errors++;
                $display("FAIL tx_start_double: tx_start high two cycles in a row at %0t", $time);
            end
        end
        if (frame_err === 1'b1) fe_count++;
        if (z_frame_err === 1'b1) fe0_count++;
        if (tx_start === 1'b1) txs_count++;
        prev_tx = (reset === 1'b1) ? tx_start : 1'b0;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; rx_done = 1'b0; tx_done = 1'b0; tick = 1'b0; from_rx = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        from_rx = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        from_rx = 8'($urandom);
    endtask

    task automatic gap(input int gap_max);
        int n;
        n = $urandom_range(0, gap_max);
        for (int j = 0; j < n; j++) begin
            tx_done = ($urandom_range(0, 3) == 0);
            step();
            tx_done = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] a, b, input logic [7:0] op, input int gap_max);
        for (int i = 0; i < NB; i++) begin gap(gap_max); send_byte(a[8*i +: 8]); end
        for (int i = 0; i < NB; i++) begin gap(gap_max); send_byte(b[8*i +: 8]); end
        gap(gap_max);
        send_byte(op);
    endtask

    // Called right after the opcode byte was accepted.
    task automatic run_response(input logic [DATA_W-1:0] a, b, input logic [7:0] op, input bit drop);
        logic [DATA_W-1:0] res;
        logic [7:0] exp;
        int n, d;
        res = alu_fn(a, b, op);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_latch: busy=%b required 1", busy);
        end
        checks++;
        if ({num_a, num_b, opcode} !== {a, b, op}) begin
            errors++; $display("FAIL operands: a=%h b=%h op=%h required %h %h %h", num_a, num_b, opcode, a, b, op);
        end
        for (int i = 0; i < NB; i++) exp_q.push_back(res[8*i +: 8]);
        for (int i = 0; i < NB; i++) begin
            n = 0;
            while (tx_start !== 1'b1 && n < 20) begin step(); n++; end
            checks++;
            if (n != ((i == 0) ? 2 : 1)) begin
                errors++; $display("FAIL tx_latency: byte %0d after %0d cycles required %0d", i, n, (i == 0) ? 2 : 1);
            end
            if (tx_start !== 1'b1) begin exp_q.delete(); return; end
            exp = exp_q.pop_front();
            checks++;
            if (to_tx !== exp || leds !== exp || busy !== 1'b1) begin
                errors++; $display("FAIL tx_byte: to_tx=%h leds=%h busy=%b required %h %h 1", to_tx, leds, busy, exp, exp);
            end
            d = drop ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                if (drop) begin rx_done = 1'b1; from_rx = 8'($urandom); end
                step();
                rx_done = 1'b0;
            end
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++; $display("FAIL busy_end: busy=%b tx_start=%b required 0 0", busy, tx_start);
        end
        checks++;
        if ({num_a, num_b, opcode} !== {a, b, op}) begin
            errors++; $display("FAIL operands_end: a=%h b=%h op=%h required %h %h %h", num_a, num_b, opcode, a, b, op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_done = 1'b0; tx_done = 1'b0; tick = 1'b0; from_rx = '0;
        step();
        checks++;
        if ({num_a, num_b, opcode, to_tx, leds} !== '0) begin
            errors++; $display("FAIL reset_regs: a=%h b=%h op=%h to_tx=%h leds=%h required 0", num_a, num_b, opcode, to_tx, leds);
        end
        checks++;
        if ({tx_start, busy, frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: tx_start=%b busy=%b frame_err=%b required 000", tx_start, busy, frame_err);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        apply_reset();
        send_frame(16'h1234, 16'h5678, 8'h00, 0);
        checks++;
        if (num_a !== 16'h1234 || num_b !== 16'h5678) begin
            errors++; $display("FAIL basic_operands: a=%h b=%h required 1234 5678", num_a, num_b);
        end
        run_response(16'h1234, 16'h5678, 8'h00, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [DATA_W-1:0] a, b;
        logic [7:0] op;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            a = DATA_W'($urandom); b = DATA_W'($urandom); op = 8'($urandom);
            send_frame(a, b, op, 4);
            run_response(a, b, op, 1'b0);
        end
    endtask

    task automatic test_drop_rx_in_wait();
        logic [DATA_W-1:0] a, b;
        logic [7:0] op;
        for (int k = 0; k < 3; k++) begin
            a = DATA_W'($urandom); b = DATA_W'($urandom); op = 8'($urandom);
            send_frame(a, b, op, 2);
            run_response(a, b, op, 1'b1);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b0, b1, b2, op;
        logic [DATA_W-1:0] a, b;
        int base;
        apply_reset();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        send_byte(b0); send_byte(b1); send_byte(b2);
        base = fe_count;
        tick = 1'b1;
        repeat (T) step();
        tick = 1'b0;
        checks++;
        if (frame_err !== 1'b0 || fe_count != base) begin
            errors++; $display("FAIL early_frame_err: frame_err=%b count=%0d required 0 %0d", frame_err, fe_count, base);
        end
        step();
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL frame_err_pulse: frame_err=%b required 1", frame_err);
        end
        step(); step();
        checks++;
        if (fe_count != base + 1 || busy !== 1'b0) begin
            errors++; $display("FAIL frame_err_count: count=%0d busy=%b required %0d 0", fe_count - base, busy, 1);
        end
        checks++;
        if (num_a !== {b1, b0} || num_b[7:0] !== b2 || leds !== b2 || opcode !== 8'h00) begin
            errors++; $display("FAIL timeout_retain: a=%h b=%h leds=%h op=%h required %h lane0 %h %h 00", num_a, num_b, leds, opcode, {b1, b0}, b2, b2);
        end
        a = DATA_W'($urandom); b = DATA_W'($urandom); op = 8'($urandom);
        send_frame(a, b, op, 2);
        run_response(a, b, op, 1'b0);
    endtask

    task automatic test_rx_at_timeout();
        logic [7:0] b0, b1, op;
        logic [DATA_W-1:0] b;
        int base;
        apply_reset();
        b0 = 8'($urandom); b1 = 8'($urandom); b = DATA_W'($urandom); op = 8'($urandom);
        base = fe_count;
        send_byte(b0);
        tick = 1'b1;
        repeat (T) step();
        tick = 1'b0;
        send_byte(b1);
        step(); step(); step();
        checks++;
        if (fe_count != base || num_a !== {b1, b0}) begin
            errors++; $display("FAIL rx_wins: frame_errs=%0d a=%h required 0 %h", fe_count - base, num_a, {b1, b0});
        end
        for (int i = 0; i < NB; i++) send_byte(b[8*i +: 8]);
        send_byte(op);
        run_response({b1, b0}, b, op, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        logic [DATA_W-1:0] a, b;
        logic [7:0] op;
        int n, base;
        apply_reset();
        a = DATA_W'($urandom); b = DATA_W'($urandom); op = 8'($urandom);
        send_frame(a, b, op, 1);
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (tx_start !== 1'b1) begin
            errors++; $display("FAIL wait_first_byte: tx_start=%b required 1", tx_start);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({num_a, num_b, opcode, to_tx, leds, tx_start, busy, frame_err} !== '0) begin
            errors++; $display("FAIL reset_abort: a=%h b=%h op=%h to_tx=%h leds=%h tx=%b busy=%b fe=%b required 0",
                               num_a, num_b, opcode, to_tx, leds, tx_start, busy, frame_err);
        end
        reset = 1'b1;
        base = txs_count;
        a = DATA_W'($urandom); b = DATA_W'($urandom); op = 8'($urandom);
        for (int i = 0; i < NB; i++) begin gap(3); send_byte(a[8*i +: 8]); end
        for (int i = 0; i < NB; i++) begin gap(3); send_byte(b[8*i +: 8]); end
        gap(20);
        checks++;
        if (txs_count != base || busy !== 1'b0) begin
            errors++; $display("FAIL no_tx_after_reset: tx_starts=%0d busy=%b required 0 0", txs_count - base, busy);
        end
        send_byte(op);
        run_response(a, b, op, 1'b0);
    endtask

    task automatic test_no_timeout();
        logic [DATA_W-1:0] a, b, res;
        logic [7:0] bytes[$];
        int n, base;
        apply_reset();
        a = DATA_W'($urandom); b = DATA_W'($urandom);
        bytes.delete();
        for (int i = 0; i < NB; i++) bytes.push_back(a[8*i +: 8]);
        for (int i = 0; i < NB; i++) bytes.push_back(b[8*i +: 8]);
        bytes.push_back(8'h02);
        base = fe0_count;
        foreach (bytes[i]) begin
            if (i > 0) begin
                tick = 1'b1;
                repeat (6000) step();
                tick = 1'b0;
            end
            send_byte(bytes[i]);
        end
        checks++;
        if (fe0_count != base) begin
            errors++; $display("FAIL disabled_timeout: frame_errs=%0d required 0", fe0_count - base);
        end
        checks++;
        if ({z_num_a, z_num_b, z_opcode} !== {a, b, 8'h02}) begin
            errors++; $display("FAIL disabled_operands: a=%h b=%h op=%h required %h %h 02", z_num_a, z_num_b, z_opcode, a, b);
        end
        res = alu_fn(a, b, 8'h02);
        for (int i = 0; i < NB; i++) begin
            n = 0;
            while (z_tx_start !== 1'b1 && n < 20) begin step(); n++; end
            checks++;
            if (z_tx_start !== 1'b1 || z_to_tx !== res[8*i +: 8]) begin
                errors++; $display("FAIL disabled_tx_byte: tx=%b to_tx=%h required 1 %h", z_tx_start, z_to_tx, res[8*i +: 8]);
            end
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        checks++;
        if (z_busy !== 1'b0) begin
            errors++; $display("FAIL disabled_busy_end: busy=%b required 0", z_busy);
        end
    endtask

    initial begin
        reset = 1'b0; rx_done = 1'b0; tx_done = 1'b0; tick = 1'b0; from_rx = '0;
        step();
        test_reset();
        test_basic();
        test_random_frames();
        test_drop_rx_in_wait();
        test_timeout();
        test_rx_at_timeout();
        test_reset_in_wait();
        test_no_timeout();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_alu_frame_ctrl.md
UART_ALU_FRAME_CTRL -- requirements
Module: uart_alu_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: operand/result width in bits; SHALL be a multiple of 8, >= 8; NB = DATA_W/8 bytes per operand.
REQ-002 Parameter TIMEOUT_TICKS, default 16'd4096: max tick pulses allowed between bytes inside a frame; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-005 rx_done  input  1  one-cycle pulse, from_rx valid.
REQ-006 from_rx  input  8  received UART byte.
REQ-007 tx_done  input  1  one-cycle pulse, transmitter finished the current byte.
REQ-008 tick  input  1  baud-rate tick pulse.
REQ-009 from_alu  input  DATA_W  combinational ALU result of num_a, num_b, opcode.
REQ-010 num_a, num_b  output  DATA_W  assembled operands to ALU.
REQ-011 opcode  output  8  ALU operation code.
REQ-012 to_tx  output  8  byte to transmitter.
REQ-013 tx_start  output  1  one-cycle transmit request.
REQ-014 leds  output  8  last byte received or sent.
REQ-015 busy  output  1  high while result is latched or transmitted.
REQ-016 frame_err  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-017 Frame SHALL be: NB bytes num_a, NB bytes num_b, 1 byte opcode; response SHALL be NB bytes of result; all multi-byte values little-endian (byte 0 = bits 7:0 first).
REQ-018 States SHALL be NUMA, NUMB, OPCODE, LATCH, SEND, WAIT; a byte index idx (0..NB-1) selects the lane.
REQ-019 NUMA/NUMB: on rx_done, from_rx written to lane idx of num_a/num_b, leds <= from_rx; idx==NB-1 -> idx<=0, next state; else idx<=idx+1.
REQ-020 OPCODE: on rx_done, opcode <= from_rx, leds <= from_rx, state <= LATCH.
REQ-021 LATCH (exactly 1 cycle): internal result register <= from_alu, idx<=0, state <= SEND.
REQ-022 SEND (1 cycle): to_tx <= result lane idx, leds <= same byte, tx_start <= 1, state <= WAIT.
REQ-023 WAIT: tx_start <= 0; on tx_done: idx==NB-1 -> idx<=0, state <= NUMA; else idx<=idx+1, state <= SEND.
REQ-024 tx_start SHALL never be high two consecutive cycles; tx_done outside WAIT SHALL be ignored.
REQ-025 rx_done during LATCH/SEND/WAIT SHALL be dropped without changing any register.
REQ-026 busy SHALL be 1 exactly when state is LATCH, SEND or WAIT.
REQ-027 Timeout counter SHALL clear on every rx_done and whenever state is NUMA with idx==0; otherwise in NUMA/NUMB/OPCODE it increments on tick.
REQ-028 When counter reaches TIMEOUT_TICKS (non-zero): state <= NUMA, idx <= 0, counter <= 0, frame_err pulses 1 cycle; num_a, num_b, opcode, leds retain values.
REQ-029 rx_done and timeout in the same cycle: rx_done SHALL win, no frame_err.
REQ-030 Unreachable state encodings SHALL go to NUMA with idx 0 next cycle.
REQ-031 Counter width SHALL hold TIMEOUT_TICKS without wrap.

Reset
REQ-032 reset==0 at a clk edge SHALL set num_a, num_b, opcode, to_tx, leds, result register, idx, counter to 0; tx_start, busy, frame_err to 0; state to NUMA.
REQ-033 Reset mid-frame or mid-transmission SHALL abort immediately; tx_start SHALL be 0 the cycle after reset asserts.

Verification (DATA_W=16)
REQ-034 Bytes 34,12,78,56,op -> num_a=16'h1234, num_b=16'h5678; one cycle after LATCH, tx_start with to_tx=LSB of from_alu; after tx_done, second tx_start with MSB; after second tx_done, busy=0, state NUMA.
REQ-035 Send 3 bytes, then idle TIMEOUT_TICKS ticks -> single frame_err pulse; next 5 bytes form a correct new frame.
REQ-036 rx_done pulses during WAIT -> num_a/num_b/opcode unchanged, result bytes unaltered.
REQ-037 rx_done on the same cycle the counter hits TIMEOUT_TICKS -> byte accepted, no frame_err.
REQ-038 reset=0 asserted in WAIT after first result byte -> all outputs 0 next cycle; no further tx_start until a full new frame.
REQ-039 TIMEOUT_TICKS=0, 1,000,000 ticks between bytes -> no frame_err, frame completes normally.
